arbitro_memoria_dados: RTL and testbench

- Two-port arbiter/sequencer in front of the single-port data memory (32-bit words, combinational read, synchronous write).
- Shares the memory between requester 0 (CPU load/store unit) and requester 1 (DMA/debug loader).
- Uses round-robin priority and a req/ack handshake with registered read data.
- Drives the memory's address, write-data and write-enable inputs, and captures its read data.

---
 rtl/arbitro_memoria_dados_if.sv | 31 +++
 rtl/arbitro_memoria_dados.sv | 103 ++++++++++
 tb/tb_arbitro_memoria_dados.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_dados_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// The design takes the slave view; the environment driving it takes the master view.
interface arbitro_memoria_dados_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// Each access takes IDLE -> ACCESS -> RESPOND; read data is registered per port.
module arbitro_memoria_dados (
  input  logic                          clk,
  input  logic                          reset,
  arbitro_memoria_dados_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t      state_reg, state_next;
  logic        winner_reg;
  logic        last_grant_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg [2];

  logic [1:0]  req_vec;
  logic [1:0]  we_vec;
  logic [31:0] addr_vec  [2];
  logic [31:0] wdata_vec [2];
  logic [1:0]  ack_vec;
  logic        grant_valid;
  logic        grant_idx;

  assign req_vec      = {bus.req1, bus.req0};
  assign we_vec       = {bus.we1, bus.we0};
  assign addr_vec[0]  = bus.addr0;
  assign addr_vec[1]  = bus.addr1;
  assign wdata_vec[0] = bus.wdata0;
  assign wdata_vec[1] = bus.wdata1;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant_valid = |req_vec;
    grant_idx   = 1'b0;
    if (&req_vec) begin
      grant_idx = ~last_grant_reg;
    end else begin
      grant_idx = req_vec[1];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      winner_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && grant_valid) begin
        winner_reg <= grant_idx;
        we_reg     <= we_vec[grant_idx];
        addr_reg   <= addr_vec[grant_idx];
        wdata_reg  <= wdata_vec[grant_idx];
      end
      if (state_reg == RESPOND) begin
        last_grant_reg <= winner_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT = 1'(gi);

      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg[gi] <= 32'd0;
        end else if (state_reg == ACCESS && !we_reg && winner_reg == PORT) begin
          rdata_reg[gi] <= bus.mem_rdata;
        end
      end

      // Gated by reset so an interrupted transaction never completes.
      assign ack_vec[gi] = (state_reg == RESPOND) && (winner_reg == PORT) && !reset;
    end
  endgenerate

  assign bus.ack0      = ack_vec[0];
  assign bus.ack1      = ack_vec[1];
  assign bus.rdata0    = rdata_reg[0];
  assign bus.rdata1    = rdata_reg[1];
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_we    = (state_reg == ACCESS) && we_reg && !reset;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Scoreboard bench for arbitro_memoria_dados with a behavioural 64-word memory.
// Stimulus pushes expected acks; a negedge monitor pops and checks them.
module tb_arbitro_memoria_dados;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arbitro_memoria_dados_if bus ();

  arbitro_memoria_dados dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural memory: combinational read, synchronous write.
  logic [31:0] mem [0:63];
  logic        mem_clear = 1'b1;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = 6'd0;
  logic [31:0] pre_data = 32'd0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        exp_item;
  logic [31:0] exp_rdata [2];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(int word, logic [31:0] data);
    pre_addr = 6'(word);
    pre_data = data;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic drive(int port, logic we, logic [31:0] addr, logic [31:0] wdata);
    if (port == 0) begin
      bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
  endtask

  // Issue a request and record the ack it must produce with the rdata expected then.
  task automatic issue(int port, logic we, logic [31:0] addr, logic [31:0] wdata,
                       logic [31:0] exp_rd);
    exp_t e;
    drive(port, we, addr, wdata);
    exp_rdata[port] = exp_rd;
    e.port = port;
    e.data = exp_rd;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      check("ack_overlap", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        $display("ack port %0d rdata0 %h rdata1 %h", bus.ack1 ? 1 : 0, bus.rdata0, bus.rdata1);
        check("ack_port", bus.ack1 ? 32'd1 : 32'd0, 32'(exp_item.port));
        check("ack_rdata", exp_item.port == 0 ? bus.rdata0 : bus.rdata1, exp_item.data);
      end
    end
  end

  int ack_cycle [4];
  int ack_port  [4];
  int n_ack;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 32'd0; bus.addr1 = 32'd0;
    bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    tick();
    tick();
    mem_clear = 1'b0;
    reset = 1'b0;

    check("rst_ack0", {31'd0, bus.ack0}, 32'd0);
    check("rst_ack1", {31'd0, bus.ack1}, 32'd0);
    check("rst_rdata0", bus.rdata0, 32'd0);
    check("rst_rdata1", bus.rdata1, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Single store from port 0.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0);
    tick();
    check("st_mem_we", {31'd0, bus.mem_we}, 32'd1);
    check("st_mem_addr", bus.mem_addr, 32'h10);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("st_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check("st_ack0", {31'd0, bus.ack0}, 32'd1);
    check("st_mem_we_off", {31'd0, bus.mem_we}, 32'd0);
    check("st_mem4", mem[4], 32'hDEADBEEF);
    check("st_rdata0", bus.rdata0, 32'd0);
    tick();
    bus.req0 = 1'b0;
    check("st_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Single load on port 1.
    preload(4, 32'hCAFEF00D);
    issue(1, 1'b0, 32'h10, 32'd0, 32'hCAFEF00D);
    tick();
    check("ld_mem_we", {31'd0, bus.mem_we}, 32'd0);
    tick();
    check("ld_ack1", {31'd0, bus.ack1}, 32'd1);
    check("ld_mem_we2", {31'd0, bus.mem_we}, 32'd0);
    check("ld_rdata1", bus.rdata1, 32'hCAFEF00D);
    check("ld_rdata0", bus.rdata0, 32'd0);
    tick();
    bus.req1 = 1'b0;

    // Back-to-back loads on port 0 with req held throughout.
    preload(0, 32'h1000_0000);
    preload(1, 32'h1000_0001);
    preload(2, 32'h1000_0002);
    preload(3, 32'h1000_0003);
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'(4 * i), 32'd0, 32'h1000_0000 + 32'(i));
      tick();
      check("b2b_busy_access", {31'd0, bus.busy}, 32'd1);
      tick();
      check("b2b_ack0", {31'd0, bus.ack0}, 32'd1);
      check("b2b_rdata0", bus.rdata0, 32'h1000_0000 + 32'(i));
      tick();
      check("b2b_busy_idle", {31'd0, bus.busy}, 32'd0);
      if (i == 3) bus.req0 = 1'b0;
    end

    // Reset during ACCESS of a port-1 store.
    preload(8, 32'h0BADC0DE);
    drive(1, 1'b1, 32'h20, 32'h12345678);
    tick();
    check("rst_mid_access_we", {31'd0, bus.mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we_gated", {31'd0, bus.mem_we}, 32'd0);
    tick();
    reset = 1'b0;
    bus.req1 = 1'b0;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    check("rst_mid_ack1", {31'd0, bus.ack1}, 32'd0);
    check("rst_mid_ack0", {31'd0, bus.ack0}, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mid_rdata0", bus.rdata0, 32'd0);
    check("rst_mid_rdata1", bus.rdata1, 32'd0);
    check("rst_mid_mem8", mem[8], 32'h0BADC0DE);

    // Tie with both requests held: must alternate starting with port 0.
    preload(16, 32'hA1A1A1A1);
    preload(17, 32'hB2B2B2B2);
    issue(0, 1'b0, 32'h40, 32'd0, 32'hA1A1A1A1);
    issue(1, 1'b0, 32'h44, 32'd0, 32'hB2B2B2B2);
    exp_item.port = 0; exp_item.data = 32'hA1A1A1A1; exp_q.push_back(exp_item);
    exp_item.port = 1; exp_item.data = 32'hB2B2B2B2; exp_q.push_back(exp_item);
    n_ack = 0;
    for (int c = 0; c < 20 && n_ack < 4; c++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        ack_cycle[n_ack] = c;
        ack_port[n_ack]  = bus.ack1 ? 1 : 0;
        n_ack++;
      end
    end
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("tie_ack_count", 32'(n_ack), 32'd4);
    if (n_ack == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("tie_order", 32'(ack_port[k]), 32'(k % 2));
        if (k > 0) check("tie_spacing", 32'(ack_cycle[k] - ack_cycle[k-1]), 32'd3);
      end
    end

    // Fields change while the store is in flight; latched values must be used.
    preload(12, 32'h0);
    preload(13, 32'h13131313);
    issue(0, 1'b1, 32'h30, 32'hAAAA5555, exp_rdata[0]);
    tick();
    bus.addr0  = 32'h34;
    bus.wdata0 = 32'h11111111;
    #1;
    check("fc_mem_addr", bus.mem_addr, 32'h30);
    check("fc_mem_wdata", bus.mem_wdata, 32'hAAAA5555);
    tick();
    check("fc_ack0", {31'd0, bus.ack0}, 32'd1);
    check("fc_mem12", mem[12], 32'hAAAA5555);
    check("fc_mem13", mem[13], 32'h13131313);
    tick();
    bus.req0 = 1'b0;

    tick();
    tick();
    check("pending_acks", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
